// File: rtl/rv32i_alu_issue.sv
// Execute-stage sequencer for the rv32i ALU: decodes one ALU/branch request per handshake,
// drives registered operands into the ALU, captures its result/flags and returns a response.
module rv32i_alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_kind_i,
  input  logic [2:0]      req_funct3_i,
  input  logic            req_funct7b5_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  input  logic [XLEN-1:0] req_imm_i,
  input  logic [4:0]      req_rd_i,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] alu_operand1_o,
  output logic [XLEN-1:0] alu_operand2_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_equal_i,
  input  logic            alu_less_i,
  input  logic            alu_less_signed_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_result_o,
  output logic [4:0]      rsp_rd_o,
  output logic            rsp_wb_o,
  output logic            rsp_taken_o,
  output logic            rsp_illegal_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_EVAL, ST_RESP} state_e;

  localparam logic [1:0] KIND_RR = 2'd0;
  localparam logic [1:0] KIND_RI = 2'd1;
  localparam logic [1:0] KIND_BR = 2'd2;
  localparam logic [3:0] OP_SUB  = 4'b1000;

  state_e          state_q, state_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [XLEN-1:0] operand1_q, operand1_d;
  logic [XLEN-1:0] operand2_q, operand2_d;
  logic [4:0]      rd_q, rd_d;
  logic            is_branch_q, is_branch_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            wb_q, wb_d;
  logic            taken_q, taken_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  logic            req_illegal;
  logic            br_taken;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_operand2;

  assign req_ready_o = (state_q == ST_IDLE) && !reset_i;
  assign accept      = req_valid_i && req_ready_o;

  // Request decode: ALU op code, second operand source and illegal encodings.
  always_comb begin
    req_illegal  = 1'b0;
    dec_op       = {req_funct7b5_i, req_funct3_i};
    dec_operand2 = req_rs2_i;
    case (req_kind_i)
      KIND_RR: req_illegal = req_funct7b5_i && (req_funct3_i != 3'b000) && (req_funct3_i != 3'b101);
      KIND_RI: begin
        dec_operand2 = req_imm_i;
        dec_op       = (req_funct3_i == 3'b101) ? {req_funct7b5_i, 3'b101} : {1'b0, req_funct3_i};
        req_illegal  = (req_funct3_i == 3'b001) && req_funct7b5_i;
      end
      KIND_BR: begin
        dec_op      = OP_SUB;
        req_illegal = (req_funct3_i == 3'b010) || (req_funct3_i == 3'b011);
      end
      default: req_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (funct3_q)
      3'b000:  br_taken = alu_equal_i;
      3'b001:  br_taken = !alu_equal_i;
      3'b100:  br_taken = alu_less_signed_i;
      3'b101:  br_taken = !alu_less_signed_i;
      3'b110:  br_taken = alu_less_i;
      3'b111:  br_taken = !alu_less_i;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    operand1_d  = operand1_q;
    operand2_d  = operand2_q;
    rd_d        = rd_q;
    is_branch_d = is_branch_q;
    funct3_d    = funct3_q;
    result_d    = result_q;
    wb_d        = wb_q;
    taken_d     = taken_q;
    illegal_d   = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rd_d = req_rd_i;
          if (req_illegal) begin
            // Illegal requests bypass the ALU and leave its operand registers untouched.
            illegal_d = 1'b1;
            result_d  = '0;
            wb_d      = 1'b0;
            taken_d   = 1'b0;
            state_d   = ST_RESP;
          end else begin
            alu_op_d    = dec_op;
            operand1_d  = req_rs1_i;
            operand2_d  = dec_operand2;
            is_branch_d = (req_kind_i == KIND_BR);
            funct3_d    = req_funct3_i;
            illegal_d   = 1'b0;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_EVAL;
      ST_EVAL: begin
        result_d = is_branch_q ? '0 : alu_result_i;
        wb_d     = !is_branch_q && (rd_q != 5'd0);
        taken_d  = is_branch_q && br_taken;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      alu_op_q    <= '0;
      operand1_q  <= '0;
      operand2_q  <= '0;
      rd_q        <= '0;
      is_branch_q <= 1'b0;
      funct3_q    <= '0;
      result_q    <= '0;
      wb_q        <= 1'b0;
      taken_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      operand1_q  <= operand1_d;
      operand2_q  <= operand2_d;
      rd_q        <= rd_d;
      is_branch_q <= is_branch_d;
      funct3_q    <= funct3_d;
      result_q    <= result_d;
      wb_q        <= wb_d;
      taken_q     <= taken_d;
      illegal_q   <= illegal_d;
    end
  end

  assign alu_op_o       = alu_op_q;
  assign alu_operand1_o = operand1_q;
  assign alu_operand2_o = operand2_q;
  assign rsp_valid_o    = (state_q == ST_RESP);
  assign rsp_result_o   = result_q;
  assign rsp_rd_o       = rd_q;
  assign rsp_wb_o       = wb_q;
  assign rsp_taken_o    = taken_q;
  assign rsp_illegal_o  = illegal_q;

endmodule
